// File: rtl/spi_slave_dma_rx.sv
`default_nettype none
// =============================================================================
// Module   : spi_slave_dma_rx
// Purpose  : SPI receive slave; packs MOSI units into words and DMAs them to
//            PSRAM through one qpimem_arb write port.
// Revision : 2.0 - unit length, bit order, sample edge, limit, counters, irq
// =============================================================================
module spi_slave_dma_rx #(
    parameter int FIFO_WORDS  = 512,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_BITS   = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           register_num,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    input  logic                 wen,
    input  logic                 ren,
    output logic                 ready,
    output logic                 qpimem_arb_do_write,
    input  logic                 qpimem_arb_next_word,
    output logic [ADDR_BITS-1:0] qpimem_arb_addr,
    output logic [31:0]          qpimem_arb_wdata,
    input  logic                 qpimem_arb_holding,
    input  logic                 SCK,
    input  logic                 MOSI,
    input  logic                 CS,
    output logic                 MISO,
    output logic                 irq
);
    localparam int c_PTR_BITS = $clog2(FIFO_WORDS);
    localparam logic [c_PTR_BITS:0] c_FULL_COUNT = FIFO_WORDS[c_PTR_BITS:0];

    // Register file
    logic        r_enable, r_lsb_first, r_sample_fall, r_irq_en;
    logic        r_overflow, r_done, r_fragment;
    logic [1:0]  r_unit_len;
    logic [31:0] r_dest, r_limit, r_data_out;

    // SPI pin synchronisers and edge pulses
    logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_cs_sync;
    logic r_sck_prev, r_cs_prev, r_sck_rise, r_sck_fall, r_cs_rise, r_cs_fall, r_mosi_bit;

    // Transfer state
    logic        r_active, r_in_xfer, r_wait_done;
    logic        r_cfg_lsb, r_cfg_fall;
    logic [1:0]  r_cfg_len;
    logic [31:0] r_cfg_limit, r_shift, r_pack, r_rx_bytes, r_words, r_pushed;
    logic [4:0]  r_bit_cnt;
    logic [1:0]  r_pack_bytes;
    logic [ADDR_BITS-1:0] r_addr;

    // FIFO
    logic [31:0]           r_mem [FIFO_WORDS];
    logic [c_PTR_BITS-1:0] r_wptr, r_rptr;
    logic [c_PTR_BITS:0]   r_count, w_count_next;
    logic                  r_do_write;

    logic        w_busy, w_start, w_live, w_shift_en, w_unit_done, w_under_limit;
    logic        w_push_req, w_push, w_drop, w_pop, w_empty, w_full, w_set_frag, w_set_done;
    logic [2:0]  w_unit_bytes, w_pack_sum;
    logic [4:0]  w_last_bit;
    logic [31:0] w_shift_next, w_unit, w_pack_merge, w_push_data, w_clr, w_rdata;
    logic        w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_sync  <= '1;
            r_mosi_sync <= '1;
            r_cs_sync   <= '1;
            r_sck_prev  <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_sck_rise  <= 1'b0;
            r_sck_fall  <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_mosi_bit  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
            r_sck_rise  <= r_sck_sync[SYNC_STAGES-1] & ~r_sck_prev;
            r_sck_fall  <= ~r_sck_sync[SYNC_STAGES-1] & r_sck_prev;
            r_cs_rise   <= r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
            r_cs_fall   <= ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
            r_mosi_bit  <= r_mosi_sync[SYNC_STAGES-1];
        end
    end

    assign w_busy  = ~r_cs_sync[SYNC_STAGES-1];
    assign w_start = r_cs_fall & r_enable;
    assign w_live  = r_active & r_enable;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_COUNT);

    always_comb begin
        w_unit_bytes = 3'd4;
        w_last_bit   = 5'd31;
        case (r_cfg_len)
            2'd0:    begin w_unit_bytes = 3'd1; w_last_bit = 5'd7;  end
            2'd1:    begin w_unit_bytes = 3'd2; w_last_bit = 5'd15; end
            default: begin w_unit_bytes = 3'd4; w_last_bit = 5'd31; end
        endcase
        // The shifter is cleared per unit: MSB-first units sit in the low bits,
        // LSB-first units enter at bit 31 and are right-aligned afterwards.
        w_shift_next = r_cfg_lsb ? {r_mosi_bit, r_shift[31:1]} : {r_shift[30:0], r_mosi_bit};
        w_unit       = r_cfg_lsb ? (w_shift_next >> (5'd31 - w_last_bit)) : w_shift_next;
        w_pack_merge = r_pack | (w_unit << {r_pack_bytes, 3'b000});
        w_pack_sum   = {1'b0, r_pack_bytes} + w_unit_bytes;
    end

    assign w_shift_en    = w_live & (r_cfg_fall ? r_sck_fall : r_sck_rise);
    assign w_unit_done   = w_shift_en & (r_bit_cnt == w_last_bit);
    assign w_push_req    = (w_unit_done & w_pack_sum[2]) |
                           (r_cs_rise & w_live & (r_pack_bytes != 2'd0));
    assign w_push_data   = w_unit_done ? w_pack_merge : r_pack;
    assign w_under_limit = (r_cfg_limit == 32'd0) || (r_pushed < r_cfg_limit);
    assign w_push        = w_push_req & w_under_limit & ~w_full;
    assign w_drop        = w_push_req & w_under_limit & w_full;
    assign w_pop         = qpimem_arb_next_word & ~w_empty;
    assign w_set_frag    = r_cs_rise & w_live & (r_bit_cnt != 5'd0);
    assign w_set_done    = r_wait_done & w_empty;
    assign w_count_next  = w_start ? '0 :
                           r_count + {{c_PTR_BITS{1'b0}}, w_push} - {{c_PTR_BITS{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;  r_in_xfer <= 1'b0;  r_wait_done <= 1'b0;
            r_cfg_lsb <= 1'b0; r_cfg_fall <= 1'b0; r_cfg_len <= 2'd0; r_cfg_limit <= '0;
            r_shift <= '0;     r_bit_cnt <= '0;    r_pack <= '0;      r_pack_bytes <= '0;
            r_rx_bytes <= '0;  r_words <= '0;      r_pushed <= '0;    r_addr <= '0;
            r_wptr <= '0;      r_rptr <= '0;       r_count <= '0;     r_do_write <= 1'b0;
        end else if (w_start) begin
            r_active <= 1'b1;  r_in_xfer <= 1'b1;  r_wait_done <= 1'b0;
            r_cfg_lsb <= r_lsb_first; r_cfg_fall <= r_sample_fall;
            r_cfg_len <= r_unit_len;  r_cfg_limit <= r_limit;
            r_shift <= '0;     r_bit_cnt <= '0;    r_pack <= '0;      r_pack_bytes <= '0;
            r_rx_bytes <= '0;  r_words <= '0;      r_pushed <= '0;
            r_addr <= {r_dest[ADDR_BITS-1:2], 2'b00};
            r_wptr <= '0;      r_rptr <= '0;       r_count <= '0;     r_do_write <= 1'b0;
        end else begin
            if (w_shift_en) begin
                if (w_unit_done) begin
                    r_shift    <= '0;
                    r_bit_cnt  <= '0;
                    r_rx_bytes <= r_rx_bytes + 32'(w_unit_bytes);
                    r_pack       <= w_pack_sum[2] ? 32'd0 : w_pack_merge;
                    r_pack_bytes <= w_pack_sum[1:0];
                end else begin
                    r_shift   <= w_shift_next;
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
            if (w_push) begin
                r_wptr   <= r_wptr + c_PTR_BITS'(1);
                r_pushed <= r_pushed + 32'd1;
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + c_PTR_BITS'(1);
                r_addr  <= r_addr + ADDR_BITS'(4);
                r_words <= r_words + 32'd1;
            end
            r_count    <= w_count_next;
            r_do_write <= (w_count_next != '0);
            if (w_drop || !r_enable)
                r_active <= 1'b0;
            if (r_cs_rise) begin
                r_active  <= 1'b0;
                r_in_xfer <= 1'b0;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_pack    <= '0;
                r_pack_bytes <= '0;
                if (r_in_xfer)
                    r_wait_done <= 1'b1;
            end else if (w_set_done) begin
                r_wait_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_push_data;
    end

    assign w_clr = (wen && register_num == 3'd0) ? data_in : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable <= 1'b0; r_lsb_first <= 1'b0; r_sample_fall <= 1'b0; r_irq_en <= 1'b0;
            r_unit_len <= 2'd0; r_dest <= '0; r_limit <= '0;
            r_overflow <= 1'b0; r_done <= 1'b0; r_fragment <= 1'b0;
        end else begin
            if (wen) begin
                case (register_num)
                    3'd0: begin
                        r_enable      <= data_in[0];
                        r_lsb_first   <= data_in[4];
                        r_sample_fall <= data_in[5];
                        r_unit_len    <= data_in[9:8];
                        r_irq_en      <= data_in[10];
                    end
                    3'd1:    r_dest  <= {data_in[31:2], 2'b00};
                    3'd2:    r_limit <= data_in;
                    default: ;
                endcase
            end
            // A set in the same cycle as a write-1-to-clear wins.
            r_overflow <= w_drop     | (r_overflow & ~w_clr[2]);
            r_done     <= w_set_done | (r_done     & ~w_clr[3]);
            r_fragment <= w_set_frag | (r_fragment & ~w_clr[11]);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (register_num)
            3'd0: w_rdata = {20'd0, r_fragment, r_irq_en, r_unit_len, 2'b00, r_sample_fall,
                             r_lsb_first, r_done, r_overflow, w_busy, r_enable};
            3'd1: w_rdata = r_dest;
            3'd2: w_rdata = r_limit;
            3'd3: w_rdata = r_rx_bytes;
            3'd4: w_rdata = r_words;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_data_out <= '0;
        else if (ren)
            r_data_out <= w_rdata;
    end

    assign data_out            = r_data_out;
    assign ready               = 1'b1;
    assign MISO                = 1'b0;
    assign irq                 = r_irq_en & (r_done | r_overflow);
    assign qpimem_arb_do_write = r_do_write;
    assign qpimem_arb_addr     = r_addr;
    assign qpimem_arb_wdata    = r_mem[r_rptr];
    assign w_unused            = qpimem_arb_holding ^ (^r_dest);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_dma_rx.sv
`default_nettype none
// =============================================================================
// Module   : tb_spi_slave_dma_rx
// Purpose  : Self-checking bench; expected DMA writes queued as SPI data is
//            sent and compared as the arbiter model accepts each word.
// Revision : 2.0
// =============================================================================
module tb_spi_slave_dma_rx;
    localparam int FIFO_WORDS = 4;

    logic        clk = 1'b0;
    logic        reset, wen, ren, ready, irq;
    logic [2:0]  register_num;
    logic [31:0] data_in, data_out, qpimem_arb_wdata;
    logic        qpimem_arb_do_write, qpimem_arb_next_word = 1'b0, qpimem_arb_holding = 1'b0;
    logic [23:0] qpimem_arb_addr;
    logic        SCK, MOSI, CS, MISO;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  sb_q[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;
    logic arb_hold = 1'b1;

    always #5 clk = ~clk;

    spi_slave_dma_rx #(.FIFO_WORDS(FIFO_WORDS), .SYNC_STAGES(2), .ADDR_BITS(24)) dut (
        .clk(clk), .reset(reset), .register_num(register_num), .data_in(data_in),
        .data_out(data_out), .wen(wen), .ren(ren), .ready(ready),
        .qpimem_arb_do_write(qpimem_arb_do_write), .qpimem_arb_next_word(qpimem_arb_next_word),
        .qpimem_arb_addr(qpimem_arb_addr), .qpimem_arb_wdata(qpimem_arb_wdata),
        .qpimem_arb_holding(qpimem_arb_holding), .SCK(SCK), .MOSI(MOSI), .CS(CS),
        .MISO(MISO), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Arbiter model: accepts words at random while not held, checks each one.
    always @(negedge clk) begin : arb_model
        wr_t e;
        if (!reset && qpimem_arb_do_write && !arb_hold && $urandom_range(0, 1) == 1) begin
            qpimem_arb_next_word = 1'b1;
            if (sb_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("dma_addr", {8'd0, qpimem_arb_addr}, {8'd0, e.addr});
                check("dma_data", qpimem_arb_wdata, e.data);
            end
        end else begin
            qpimem_arb_next_word = 1'b0;
        end
    end

    task automatic push_exp(input logic [23:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic reg_write(input logic [2:0] num, input logic [31:0] val);
        @(negedge clk);
        register_num = num; data_in = val; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] num, output logic [31:0] val);
        @(negedge clk);
        register_num = num; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        val = data_out;
    endtask

    task automatic spi_bit(input logic b);
        MOSI = b;
        repeat (4) @(negedge clk);
        SCK = 1'b1;
        repeat (4) @(negedge clk);
        SCK = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_unit(input logic [31:0] v, input int nbits, input logic lsb);
        for (int i = 0; i < nbits; i++)
            spi_bit(lsb ? v[i] : v[nbits-1-i]);
    endtask

    task automatic cs_low();
        CS = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (8) @(negedge clk);
        CS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_done();
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            reg_read(3'd0, v);
            n++;
        end while (!v[3] && n < 500);
        check("done_seen", {31'd0, v[3]}, 32'd1);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] v, w;
        reset = 1'b1; wen = 1'b0; ren = 1'b0; register_num = 3'd0; data_in = '0;
        SCK = 1'b0; MOSI = 1'b0; CS = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_do_write", {31'd0, qpimem_arb_do_write}, 32'd0);
        check("rst_addr", {8'd0, qpimem_arb_addr}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_miso_ready", {30'd0, MISO, ready}, 32'd1);
        reset = 1'b0;
        for (int r = 0; r < 5; r++) begin
            reg_read(r[2:0], v);
            check("rst_reg", v, 32'd0);
        end
        arb_hold = 1'b0;

        // 32-bit MSB-first with irq
        reg_write(3'd1, 32'h1000);
        reg_write(3'd2, 32'd0);
        reg_write(3'd0, 32'h0000_0601);
        push_exp(24'h1000, 32'hDEADBEEF);
        push_exp(24'h1004, 32'h01234567);
        cs_low();
        reg_read(3'd0, v);
        check("t1_busy", {31'd0, v[1]}, 32'd1);
        spi_unit(32'hDEADBEEF, 32, 1'b0);
        spi_unit(32'h01234567, 32, 1'b0);
        cs_high();
        wait_done();
        reg_read(3'd4, v); check("t1_words", v, 32'd2);
        reg_read(3'd3, v); check("t1_rx_bytes", v, 32'd8);
        check("t1_irq", {31'd0, irq}, 32'd1);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);
        reg_write(3'd0, 32'h0000_0E0D);
        check("t1_irq_clr", {31'd0, irq}, 32'd0);

        // 8-bit LSB-first with partial-word flush
        reg_write(3'd1, 32'h2000);
        reg_write(3'd0, 32'h0000_081D);
        push_exp(24'h2000, 32'h44332211);
        push_exp(24'h2004, 32'h00000055);
        cs_low();
        for (int i = 1; i <= 5; i++)
            spi_unit(32'(i * 17), 8, 1'b1);
        cs_high();
        wait_done();
        reg_read(3'd3, v); check("t2_rx_bytes", v, 32'd5);
        reg_read(3'd0, v); check("t2_fragment", {31'd0, v[11]}, 32'd0);
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // 16-bit, falling-edge sampling, LIMIT = 1
        reg_write(3'd1, 32'h3000);
        reg_write(3'd2, 32'd1);
        reg_write(3'd0, 32'h0000_092D);
        push_exp(24'h3000, 32'hC3D4A1B2);
        cs_low();
        spi_unit(32'hA1B2, 16, 1'b0);
        spi_unit(32'hC3D4, 16, 1'b0);
        spi_unit(32'hE5F6, 16, 1'b0);
        spi_unit(32'h0718, 16, 1'b0);
        cs_high();
        wait_done();
        reg_read(3'd3, v); check("t3_rx_bytes", v, 32'd8);
        reg_read(3'd4, v); check("t3_words", v, 32'd1);
        reg_read(3'd0, v); check("t3_overflow", {31'd0, v[2]}, 32'd0);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // FIFO overflow with the arbiter stalled
        reg_write(3'd2, 32'd0);
        reg_write(3'd1, 32'h4000);
        reg_write(3'd0, 32'h0000_0A0D);
        arb_hold = 1'b1;
        cs_low();
        for (int i = 0; i < 6; i++) begin
            w = {8'(i + 1), 24'hC0FFEE};
            if (i < FIFO_WORDS)
                push_exp(24'h4000 + 24'(4 * i), w);
            spi_unit(w, 32, 1'b0);
        end
        cs_high();
        reg_read(3'd0, v); check("t4_overflow", {31'd0, v[2]}, 32'd1);
        check("t4_do_write", {31'd0, qpimem_arb_do_write}, 32'd1);
        arb_hold = 1'b0;
        wait_done();
        reg_read(3'd4, v); check("t4_words", v, 32'd4);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // 13 bits in 8-bit mode
        reg_write(3'd1, 32'h5000);
        reg_write(3'd0, 32'h0000_080D);
        push_exp(24'h5000, 32'h0000005A);
        cs_low();
        spi_unit(32'h5A, 8, 1'b0);
        spi_unit(32'h16, 5, 1'b0);
        cs_high();
        wait_done();
        reg_read(3'd0, v); check("t5_fragment", {31'd0, v[11]}, 32'd1);
        reg_read(3'd3, v); check("t5_rx_bytes", v, 32'd1);
        reg_read(3'd4, v); check("t5_words", v, 32'd1);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset during a queued DMA burst
        reg_write(3'd1, 32'h6000);
        reg_write(3'd0, 32'h0000_0A0D);
        arb_hold = 1'b1;
        cs_low();
        for (int i = 0; i < 3; i++)
            spi_unit(32'h600D0000 + 32'(i), 32, 1'b0);
        cs_high();
        check("t6_do_write_pre", {31'd0, qpimem_arb_do_write}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_do_write_rst", {31'd0, qpimem_arb_do_write}, 32'd0);
        check("t6_addr_rst", {8'd0, qpimem_arb_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        for (int r = 0; r < 5; r++) begin
            reg_read(r[2:0], v);
            check("t6_reg", v, 32'd0);
        end
        arb_hold = 1'b0;
        reg_write(3'd1, 32'h7000);
        reg_write(3'd0, 32'h0000_0201);
        push_exp(24'h7000, 32'hCAFEF00D);
        cs_low();
        spi_unit(32'hCAFEF00D, 32, 1'b0);
        cs_high();
        wait_done();
        reg_read(3'd4, v); check("t6_words", v, 32'd1);
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_slave_dma_rx.md
# spi_slave_dma_rx

Second-generation SPI receive slave with DMA into PSRAM through `qpimem_arb`. It adds configurable unit length (8/16/32 bits), bit order, sample edge, a per-transfer word limit, partial-word flush on CS release, transfer counters and an interrupt. It sits on the peripheral register bus beside the CPU and drives one write port of `qpimem_arb`. MISO is driven low.

## Interface
- `FIFO_WORDS`, 512: DMA FIFO depth in 32-bit words; power of two, at least 4; all entries usable.
- `SYNC_STAGES`, 2: synchroniser flops per SPI pin before edge detection; at least 2.
- `ADDR_BITS`, 24: width of the PSRAM address.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `register_num` in 3: register select.
- `data_in` in 32: register write data.
- `data_out` out 32: registered read data.
- `wen`, `ren` in 1: register write strobe and read strobe.
- `ready` out 1: tied high.
- `qpimem_arb_do_write` out 1: write request.
- `qpimem_arb_next_word` in 1: current word accepted.
- `qpimem_arb_addr` out ADDR_BITS: byte address, word aligned.
- `qpimem_arb_wdata` out 32: FIFO head word.
- `qpimem_arb_holding` in 1: ignored.
- `SCK`, `MOSI`, `CS` in 1: SPI pins, asynchronous; `CS` is active low.
- `MISO` out 1: constant 0.
- `irq` out 1: level interrupt.

## Operation
Registers (reads of unused numbers return 0):
- **Reg 0 CTRL/STATUS**
  - bit0 `enable` (rw).
  - bit1 `busy` (ro): synchronised CS is low.
  - bit2 `overflow` (write 1 to clear).
  - bit3 `done` (write 1 to clear).
  - bit4 `lsb_first` (rw).
  - bit5 `sample_fall` (rw): 1 samples on the SCK falling edge.
  - bits[9:8] `unit_len` (rw): 0 = 8 bits, 1 = 16 bits, 2 or 3 = 32 bits.
  - bit10 `irq_en` (rw).
  - bit11 `fragment` (write 1 to clear).
- **Reg 1 DEST** (rw): DMA start address; bits[1:0] are ignored.
- **Reg 2 LIMIT** (rw): maximum number of 32-bit words per transfer; 0 means unlimited.
- **Reg 3 RX_BYTES** (ro): completed units × unit bytes in the current or last transfer.
- **Reg 4 WORDS_WRITTEN** (ro): words accepted by `qpimem_arb` since the last CS fall.

Reception:
- Nothing happens while `enable` = 0.
- CS fall:
  - clears the shifter, packer, both counters and the FIFO;
  - loads the address from DEST;
  - latches `unit_len`, `lsb_first`, `sample_fall` and LIMIT for the whole transfer.
- On each selected SCK edge, MOSI is shifted in; `lsb_first` = 0 means the first bit lands in the unit MSB.
- Each completed unit is packed little-endian into a 32-bit word: the first byte goes to bits[7:0], and a first 16-bit unit goes to bits[15:0].
- A full word is pushed to the FIFO.
- Once LIMIT words have been pushed, later units are counted in RX_BYTES but not stored.
- FIFO full when a word must be pushed: the word is dropped, `overflow` is set and reception stops until CS rises.
- CS rise:
  - a partially filled packed word is zero-padded and pushed, subject to LIMIT and full;
  - incomplete unit bits are discarded and set `fragment`.
- `done` is set on the first cycle after CS rise in which the FIFO is empty.
- `irq` = `irq_en` & (`done` | `overflow`).

DMA:
- `do_write` is registered and equals "FIFO non-empty".
- On `next_word` with the FIFO non-empty: pop the FIFO, add 4 to the address and increment WORDS_WRITTEN.
- The address wraps modulo 2^ADDR_BITS.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- `enable` cleared mid-transfer: reception stops immediately and queued words still drain.

Reset values:
- all registers 0, except SYNC flops and CS, which reset to 1 (idle);
- `data_out` 0, `do_write` 0, `qpimem_arb_addr` 0, `irq` 0, FIFO empty.

## Timing
- SPI pin to internal edge pulse: SYNC_STAGES + 1 clk.
- Supported SCK frequency is at most clk/4; SCK must be idle for at least SYNC_STAGES + 2 clk around CS edges.
- Completed word to `do_write` high: 2 clk; FIFO read is asynchronous or registered as long as `wdata` is valid while `do_write` is high.
- `data_out` updates on the clk after `ren`; it holds its value otherwise.
- `wen` takes effect on the next clk.
- Config changes during `busy` apply at the next CS fall; the write-1-to-clear bits apply immediately.
- A flag set and a write-1-to-clear in the same cycle: the set wins.
- Reset mid-transfer: all state returns to reset values on the next clk, and `do_write` drops on that clk.

## Test plan
- **32-bit MSB-first, DEST = 0x1000:** send 0xDEADBEEF and 0x01234567 → writes 0x1000 = 0xDEADBEEF and 0x1004 = 0x01234567; WORDS_WRITTEN = 2, `done` = 1, `irq` high when `irq_en` = 1.
- **8-bit, LSB-first:** send bytes 0x11 0x22 0x33 0x44 0x55, then raise CS → 0x44332211 at DEST and 0x00000055 at DEST + 4; RX_BYTES = 5.
- **16-bit, `sample_fall` = 1, LIMIT = 1:** send four units → one word written; RX_BYTES = 8; `overflow` = 0.
- **FIFO_WORDS = 4 with `next_word` held low:** send 6 words → 4 words accepted, `overflow` = 1; WORDS_WRITTEN = 4 after `next_word` is released.
- **CS raised after 13 bits in 8-bit mode:** one byte is stored, `fragment` = 1, RX_BYTES = 1.
- **`reset` pulsed during a DMA burst:** `do_write` = 0 on the next clk, all registers read 0, and a subsequent transfer works from DEST.
